wb_burst_sram: RTL and testbench

WB_BURST_SRAM -- requirements
Module: wb_burst_sram

---
 rtl/wb_burst_sram_pkg.sv | 39 +++
 rtl/wb_burst_sram_addr_gen.sv | 66 ++++++
 rtl/wb_burst_sram.sv | 216 +++++++++++++++++++++
 tb/tb_wb_burst_sram.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_burst_sram_pkg.sv
// wb_burst_sram_pkg -- shared configuration for the Wishbone burst SRAM bridge.
//
// Contents:
//   WB_ADDR_W   default Wishbone word-address width (macro, overridable)
//   state_t     controller state encoding
//   burst_t     latched burst length (1, 4 or 8 beats)
//   last_beat_idx()  index of the final beat for a given burst length

`ifndef WB_ADDR_W
`define WB_ADDR_W 24
`endif

package wb_burst_sram_pkg;

    // ACK_WAIT is where a burst parks between beats while the master holds cyc but not stb.
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        ACK,
        ACK_WAIT,
        ERR
    } state_t;

    typedef enum logic [1:0] {
        BL_1,
        BL_4,
        BL_8
    } burst_t;

    function automatic logic [2:0] last_beat_idx(input burst_t len);
        case (len)
            BL_8:    return 3'd7;
            BL_4:    return 3'd3;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/wb_burst_sram_addr_gen.sv
// wb_burst_addr_gen -- beat counter and wrapped burst address generator.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   load        start of a transaction: capture base address and burst length, beat = 0
//   advance     the next beat has been accepted: beat = beat + 1
//   base        base word address presented with the first beat
//   len         burst length to latch on load
//   next_addr   address the following beat must use (wraps inside the aligned 4/8 block)
//   last_beat   current beat is the final one of the burst

`ifndef WB_ADDR_W
`define WB_ADDR_W 24
`endif

module wb_burst_addr_gen
    import wb_burst_sram_pkg::*;
#(
    parameter int ADDR_W = `WB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base,
    input  burst_t            len,
    output logic [ADDR_W-1:0] next_addr,
    output logic              last_beat
);

    logic [ADDR_W-1:0] base_q;
    burst_t            len_q;
    logic [2:0]        beat;
    logic [2:0]        beat_inc;
    logic [2:0]        low8;
    logic [1:0]        low4;

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
            len_q  <= BL_1;
            beat   <= 3'd0;
        end else if (load) begin
            base_q <= base;
            len_q  <= len;
            beat   <= 3'd0;
        end else if (advance) begin
            beat <= beat + 3'd1;
        end
    end

    // Only the low k bits of the base move; the carry out of them is dropped so the
    // burst wraps inside its aligned block instead of running into the next one.
    always_comb begin
        beat_inc = beat + 3'd1;
        low8     = base_q[2:0] + beat_inc;
        low4     = base_q[1:0] + beat_inc[1:0];
        case (len_q)
            BL_8:    next_addr = {base_q[ADDR_W-1:3], low8};
            BL_4:    next_addr = {base_q[ADDR_W-1:2], low4};
            default: next_addr = base_q;
        endcase
        last_beat = (beat == last_beat_idx(len_q));
    end

endmodule

// File: rtl/wb_burst_sram.sv
// wb_burst_sram -- Wishbone slave to asynchronous 16-bit SRAM bridge with 4/8 beat bursts.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   wb_*                Wishbone slave (cyc, stb, we, adr, i_dat, sel, 4/8 burst flags,
//                       ack, err, o_dat)
//   sram_*              SRAM pins: address, write data + output enable, active-low
//                       chip/output/write enables and byte lanes, read data in
//
// Every SRAM pin and Wishbone response is a flop loaded from the decode of the next
// state, so pins change on the same edge as the state and nothing combinational
// reaches them from the Wishbone inputs.

`ifndef WB_ADDR_W
`define WB_ADDR_W 24
`endif

module wb_burst_sram
    import wb_burst_sram_pkg::*;
#(
    parameter int ADDR_W      = `WB_ADDR_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              wb_cyc,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_adr,
    input  logic [15:0]       wb_i_dat,
    input  logic [1:0]        wb_sel,
    input  logic              wb_4_burst,
    input  logic              wb_8_burst,
    output logic              wb_ack,
    output logic              wb_err,
    output logic [15:0]       wb_o_dat,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_o,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n,
    input  logic [15:0]       sram_dq_i
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t            state, state_next;
    logic              we_q, we_d;
    logic [1:0]        sel_q, sel_d;
    logic [3:0]        wait_cnt, wait_d;
    logic [ADDR_W-1:0] addr_d;
    logic [15:0]       dq_o_d, rdata_d;
    logic              ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d, dq_oe_d, ack_d, err_d;
    logic              load, advance;
    burst_t            len_d;
    logic [ADDR_W-1:0] next_addr;
    logic              last_beat;

    wb_burst_addr_gen #(
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .clk      (i_clk),
        .rst      (i_rst),
        .load     (load),
        .advance  (advance),
        .base     (wb_adr),
        .len      (len_d),
        .next_addr(next_addr),
        .last_beat(last_beat)
    );

    // Next state, beat capture, and the pin values that go with the next state.
    always_comb begin
        state_next = state;
        we_d       = we_q;
        sel_d      = sel_q;
        wait_d     = wait_cnt;
        addr_d     = sram_addr;
        dq_o_d     = sram_dq_o;
        rdata_d    = wb_o_dat;
        load       = 1'b0;
        advance    = 1'b0;
        len_d      = BL_1;

        case (state)
            IDLE: begin
                if (wb_cyc && wb_stb) begin
                    if (wb_4_burst && wb_8_burst) begin
                        state_next = ERR;
                    end else begin
                        state_next = SETUP;
                        load       = 1'b1;
                        len_d      = wb_8_burst ? BL_8 : (wb_4_burst ? BL_4 : BL_1);
                        we_d       = wb_we;
                        sel_d      = wb_sel;
                        addr_d     = wb_adr;
                        dq_o_d     = wb_i_dat;
                    end
                end
            end
            SETUP: begin
                state_next = STROBE;
                wait_d     = WAIT_LOAD;
            end
            STROBE: begin
                if (wait_cnt == 4'd0) begin
                    state_next = ACK;
                    if (!we_q && wb_cyc) begin
                        rdata_d = sram_dq_i;
                    end
                end else begin
                    wait_d = wait_cnt - 4'd1;
                end
            end
            ACK: begin
                state_next = last_beat ? IDLE : ACK_WAIT;
            end
            ACK_WAIT: begin
                // A beat whose address disagrees with the wrapped sequence is refused
                // before anything is driven onto the SRAM.
                if (wb_cyc && wb_stb) begin
                    if (wb_adr != next_addr) begin
                        state_next = ERR;
                    end else begin
                        state_next = SETUP;
                        advance    = 1'b1;
                        we_d       = wb_we;
                        sel_d      = wb_sel;
                        addr_d     = next_addr;
                        dq_o_d     = wb_i_dat;
                    end
                end
            end
            ERR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Dropping cyc abandons the transfer from any state; no response is owed.
        if (!wb_cyc) begin
            state_next = IDLE;
        end

        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;

        case (state_next)
            SETUP, STROBE, ACK: begin
                ce_n_d  = 1'b0;
                dq_oe_d = we_d;
                ub_n_d  = we_d ? ~sel_d[1] : 1'b0;
                lb_n_d  = we_d ? ~sel_d[0] : 1'b0;
                if (state_next == STROBE) begin
                    we_n_d = ~we_d;
                    oe_n_d = we_d;
                end
                ack_d = (state_next == ACK);
            end
            ERR: begin
                err_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State and all externally visible registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            sel_q      <= 2'b00;
            wait_cnt   <= 4'd0;
            wb_ack     <= 1'b0;
            wb_err     <= 1'b0;
            wb_o_dat   <= 16'h0000;
            sram_addr  <= '0;
            sram_dq_o  <= 16'h0000;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
        end else begin
            state      <= state_next;
            we_q       <= we_d;
            sel_q      <= sel_d;
            wait_cnt   <= wait_d;
            wb_ack     <= ack_d;
            wb_err     <= err_d;
            wb_o_dat   <= rdata_d;
            sram_addr  <= addr_d;
            sram_dq_o  <= dq_o_d;
            sram_dq_oe <= dq_oe_d;
            sram_ce_n  <= ce_n_d;
            sram_oe_n  <= oe_n_d;
            sram_we_n  <= we_n_d;
            sram_ub_n  <= ub_n_d;
            sram_lb_n  <= lb_n_d;
        end
    end

endmodule

// File: tb/tb_wb_burst_sram.sv
// tb_wb_burst_sram -- self-checking bench for wb_burst_sram (WAIT_CYCLES = 1).
// A small SRAM model answers the bridge; expected responses are queued as each beat
// is issued and compared when the bridge answers with ack or err.

module tb_wb_burst_sram;

    localparam int AW    = 24;
    localparam int WAITC = 1;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          wb_cyc, wb_stb, wb_we, wb_4_burst, wb_8_burst;
    logic [AW-1:0] wb_adr;
    logic [15:0]   wb_i_dat;
    logic [1:0]    wb_sel;
    logic          wb_ack, wb_err;
    logic [15:0]   wb_o_dat;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_o, sram_dq_i;
    logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_err;
        logic        chk_data;
        logic [15:0] data;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    wb_burst_sram #(
        .ADDR_W     (AW),
        .WAIT_CYCLES(WAITC)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_adr    (wb_adr),
        .wb_i_dat  (wb_i_dat),
        .wb_sel    (wb_sel),
        .wb_4_burst(wb_4_burst),
        .wb_8_burst(wb_8_burst),
        .wb_ack    (wb_ack),
        .wb_err    (wb_err),
        .wb_o_dat  (wb_o_dat),
        .sram_addr (sram_addr),
        .sram_dq_o (sram_dq_o),
        .sram_dq_oe(sram_dq_oe),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .sram_ub_n (sram_ub_n),
        .sram_lb_n (sram_lb_n),
        .sram_dq_i (sram_dq_i)
    );

    always #5 i_clk = ~i_clk;

    // SRAM model: 4K words, byte-lane writes while we_n is low, reads while oe_n is low.
    logic [15:0] mem [0:4095];
    logic        pre_en = 1'b0;
    logic [11:0] pre_addr = 12'h000;
    logic [15:0] pre_data = 16'h0000;

    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[11:0]] : 16'h0000;

    always @(posedge i_clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            if (!sram_ub_n) mem[sram_addr[11:0]][15:8] <= sram_dq_o[15:8];
            if (!sram_lb_n) mem[sram_addr[11:0]][7:0]  <= sram_dq_o[7:0];
        end
    end

    // Strobe monitor: logs the address of each strobe and the byte lanes of writes.
    logic [AW-1:0] addr_log[$];
    int            strobe_cnt  = 0;
    logic          prev_strobe = 1'b0;
    logic          wr_ub = 1'b1;
    logic          wr_lb = 1'b1;

    always @(negedge i_clk) begin
        logic strobe_now;
        strobe_now = !sram_ce_n && (!sram_oe_n || !sram_we_n);
        if (strobe_now && !prev_strobe) begin
            addr_log.push_back(sram_addr);
            strobe_cnt = strobe_cnt + 1;
        end
        if (strobe_now && !sram_we_n) begin
            wr_ub = sram_ub_n;
            wr_lb = sram_lb_n;
        end
        prev_strobe = strobe_now;
    end

    task automatic preload(input logic [11:0] a, input logic [15:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        @(negedge i_clk);
        pre_en = 1'b0;
    endtask

    // One Wishbone beat issued just after a falling edge; lat counts falling edges until
    // ack/err is seen (WAIT_CYCLES+2 for a single access). One extra edge follows so the
    // next beat starts clean; glitch flags ack+err together or a response held too long.
    task automatic wb_beat(input logic [AW-1:0] adr, input logic we, input logic [1:0] sel,
                           input logic [15:0] dat, input logic b4, input logic b8,
                           input logic keep_cyc, output logic got_ack, output logic got_err,
                           output logic [15:0] rdata, output int lat, output logic glitch);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = adr; wb_we = we; wb_sel = sel;
        wb_i_dat = dat; wb_4_burst = b4; wb_8_burst = b8;
        got_ack = 1'b0; got_err = 1'b0; rdata = 16'h0000; lat = 0; glitch = 1'b0;
        for (int i = 1; i <= 40 && !got_ack && !got_err; i++) begin
            @(negedge i_clk);
            if (wb_ack && wb_err) glitch = 1'b1;
            if (wb_ack || wb_err) begin
                got_ack = wb_ack;
                got_err = wb_err;
                rdata   = wb_o_dat;
                lat     = i;
            end
        end
        wb_stb = 1'b0;
        wb_cyc = keep_cyc;
        @(negedge i_clk);
        if (wb_ack || wb_err) glitch = 1'b1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({wb_ack, wb_err, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 8'b00011111) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b want %b", {wb_ack, wb_err, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 8'b00011111);
        end
        checks++;
        if ({wb_o_dat, sram_dq_o, sram_addr} !== {16'h0, 16'h0, 24'h0}) begin
            errors++;
            $display("[TB] FAIL reset_data: got o_dat=%h dq_o=%h addr=%h want all 0", wb_o_dat, sram_dq_o, sram_addr);
        end
        i_rst = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_single_read();
        logic a, e_, g; logic [15:0] d; int l; exp_t e;
        exp_q.push_back('{is_err: 1'b0, chk_data: 1'b1, data: 16'hBEEF, lat: WAITC + 2});
        wb_beat(24'h000100, 1'b0, 2'b11, 16'h0, 1'b0, 1'b0, 1'b0, a, e_, d, l, g);
        e = exp_q.pop_front();
        checks++;
        if (a !== 1'b1 || e_ !== e.is_err || l != e.lat) begin
            errors++;
            $display("[TB] FAIL single_read_ack: got ack=%b err=%b lat=%0d want ack=1 err=0 lat=%0d", a, e_, l, e.lat);
        end
        checks++;
        if (d !== e.data) begin
            errors++;
            $display("[TB] FAIL single_read_data: got %h want %h", d, e.data);
        end
        checks++;
        if (g !== 1'b0 || sram_ce_n !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_read_idle: got glitch=%b ce_n=%b want 0 1", g, sram_ce_n);
        end
    endtask

    task automatic test_byte_write();
        logic a, e_, g; logic [15:0] d; int l; exp_t e;
        logic [15:0] old_word, new_data;
        old_word = 16'h5566;
        new_data = 16'h12AB;
        preload(12'h200, old_word);
        exp_q.push_back('{is_err: 1'b0, chk_data: 1'b0, data: 16'h0, lat: WAITC + 2});
        wb_beat(24'h000200, 1'b1, 2'b10, new_data, 1'b0, 1'b0, 1'b0, a, e_, d, l, g);
        e = exp_q.pop_front();
        checks++;
        if (a !== 1'b1 || e_ !== e.is_err || l != e.lat || g !== 1'b0) begin
            errors++;
            $display("[TB] FAIL byte_write_ack: got ack=%b err=%b lat=%0d glitch=%b want 1 0 %0d 0", a, e_, l, g, e.lat);
        end
        checks++;
        if ({wr_ub, wr_lb} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL byte_write_lanes: got ub_n=%b lb_n=%b want 0 1", wr_ub, wr_lb);
        end
        exp_q.push_back('{is_err: 1'b0, chk_data: 1'b1, data: {new_data[15:8], old_word[7:0]}, lat: WAITC + 2});
        wb_beat(24'h000200, 1'b0, 2'b11, 16'h0, 1'b0, 1'b0, 1'b0, a, e_, d, l, g);
        e = exp_q.pop_front();
        checks++;
        if (a !== 1'b1 || d !== e.data) begin
            errors++;
            $display("[TB] FAIL byte_write_readback: got ack=%b data=%h want 1 %h", a, d, e.data);
        end
    endtask

    task automatic test_burst8();
        logic a, e_, g; logic [15:0] d; int l; exp_t e;
        logic [AW-1:0] base, ad;
        logic [AW-1:0] exp_addr[$];
        logic [2:0] lo;
        int start, acks, bad_resp;
        base = 24'h000106;
        for (int i = 0; i < 8; i++) preload(12'h100 + 12'(i), 16'hA000 + 16'(i));
        start = addr_log.size();
        acks = 0;
        bad_resp = 0;
        for (int b = 0; b < 8; b++) begin
            lo = base[2:0] + 3'(b);
            ad = {base[AW-1:3], lo};
            exp_addr.push_back(ad);
            exp_q.push_back('{is_err: 1'b0, chk_data: 1'b1, data: 16'hA000 + 16'(lo), lat: 0});
            wb_beat(ad, 1'b0, 2'b11, 16'h0, 1'b0, 1'b1, (b < 7), a, e_, d, l, g);
            e = exp_q.pop_front();
            if (a === 1'b1) acks++;
            checks++;
            if (a !== 1'b1 || e_ !== e.is_err || d !== e.data || g !== 1'b0) begin
                errors++;
                bad_resp++;
                $display("[TB] FAIL burst8_beat%0d: got ack=%b err=%b data=%h glitch=%b want 1 0 %h 0", b, a, e_, d, g, e.data);
            end
        end
        checks++;
        if (acks != 8) begin
            errors++;
            $display("[TB] FAIL burst8_acks: got %0d want 8", acks);
        end
        checks++;
        if (addr_log.size() - start != 8) begin
            errors++;
            $display("[TB] FAIL burst8_strobes: got %0d want 8", addr_log.size() - start);
        end else begin
            for (int b = 0; b < 8; b++) begin
                checks++;
                if (addr_log[start + b] !== exp_addr[b]) begin
                    errors++;
                    $display("[TB] FAIL burst8_addr%0d: got %h want %h", b, addr_log[start + b], exp_addr[b]);
                end
            end
        end
        checks++;
        if (sram_ce_n !== 1'b1 || wb_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL burst8_idle: got ce_n=%b ack=%b want 1 0", sram_ce_n, wb_ack);
        end
    endtask

    task automatic test_burst_addr_err();
        logic a, e_, g; logic [15:0] d; int l; exp_t e;
        int n;
        preload(12'h004, 16'h4444);
        exp_q.push_back('{is_err: 1'b0, chk_data: 1'b1, data: 16'h4444, lat: WAITC + 2});
        wb_beat(24'h000004, 1'b0, 2'b11, 16'h0, 1'b1, 1'b0, 1'b1, a, e_, d, l, g);
        e = exp_q.pop_front();
        checks++;
        if (a !== 1'b1 || d !== e.data || l != e.lat) begin
            errors++;
            $display("[TB] FAIL burst4_first: got ack=%b data=%h lat=%0d want 1 %h %0d", a, d, l, e.data, e.lat);
        end
        n = strobe_cnt;
        exp_q.push_back('{is_err: 1'b1, chk_data: 1'b0, data: 16'h0, lat: 1});
        wb_beat(24'h000009, 1'b0, 2'b11, 16'h0, 1'b1, 1'b0, 1'b0, a, e_, d, l, g);
        e = exp_q.pop_front();
        checks++;
        if (e_ !== 1'b1 || a !== 1'b0 || l != e.lat || g !== 1'b0) begin
            errors++;
            $display("[TB] FAIL burst4_bad_adr: got err=%b ack=%b lat=%0d glitch=%b want 1 0 %0d 0", e_, a, l, g, e.lat);
        end
        checks++;
        if (strobe_cnt != n) begin
            errors++;
            $display("[TB] FAIL burst4_bad_adr_strobe: got %0d strobes want 0", strobe_cnt - n);
        end
    endtask

    task automatic test_both_flags();
        logic a, e_, g; logic [15:0] d; int l; exp_t e;
        int n;
        n = strobe_cnt;
        exp_q.push_back('{is_err: 1'b1, chk_data: 1'b0, data: 16'h0, lat: 1});
        wb_beat(24'h000150, 1'b1, 2'b11, 16'h9999, 1'b1, 1'b1, 1'b0, a, e_, d, l, g);
        e = exp_q.pop_front();
        checks++;
        if (e_ !== 1'b1 || a !== 1'b0 || l != e.lat || g !== 1'b0) begin
            errors++;
            $display("[TB] FAIL both_flags: got err=%b ack=%b lat=%0d glitch=%b want 1 0 %0d 0", e_, a, l, g, e.lat);
        end
        checks++;
        if (strobe_cnt != n || mem[12'h150] === 16'h9999) begin
            errors++;
            $display("[TB] FAIL both_flags_sram: got %0d strobes mem=%h want 0 strobes, no write", strobe_cnt - n, mem[12'h150]);
        end
    endtask

    // Start a write, then kill it during STROBE either by dropping cyc or by reset.
    task automatic test_abort(input logic use_reset);
        logic a, e_, g; logic [15:0] d; int l; exp_t e;
        logic seen;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 24'h000300;
        wb_sel = 2'b11; wb_i_dat = 16'h1234; wb_4_burst = 1'b0; wb_8_burst = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        checks++;
        if (sram_we_n !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort%0d_in_strobe: got we_n=%b want 0", use_reset, sram_we_n);
        end
        if (use_reset) i_rst = 1'b1;
        else begin
            wb_cyc = 1'b0;
            wb_stb = 1'b0;
        end
        @(negedge i_clk);
        checks++;
        if ({sram_we_n, sram_ce_n, sram_oe_n, sram_dq_oe, wb_ack, wb_err} !== 6'b111000) begin
            errors++;
            $display("[TB] FAIL abort%0d_release: got we_n,ce_n,oe_n,oe,ack,err=%b want 111000", use_reset, {sram_we_n, sram_ce_n, sram_oe_n, sram_dq_oe, wb_ack, wb_err});
        end
        i_rst = 1'b0;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge i_clk);
            if (wb_ack || wb_err) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort%0d_no_resp: got response=%b want 0", use_reset, seen);
        end
        exp_q.push_back('{is_err: 1'b0, chk_data: 1'b1, data: 16'hA000, lat: WAITC + 2});
        wb_beat(24'h000100, 1'b0, 2'b11, 16'h0, 1'b0, 1'b0, 1'b0, a, e_, d, l, g);
        e = exp_q.pop_front();
        checks++;
        if (a !== 1'b1 || l != e.lat || d !== e.data) begin
            errors++;
            $display("[TB] FAIL abort%0d_recover: got ack=%b lat=%0d data=%h want 1 %0d %h", use_reset, a, l, d, e.lat, e.data);
        end
    endtask

    task automatic test_back_to_back();
        logic a, e_, g; logic [15:0] d; int l; exp_t e;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{is_err: 1'b0, chk_data: 1'b1, data: 16'hA005 + 16'(i), lat: WAITC + 2});
            wb_beat(24'h000105 + 24'(i), 1'b0, 2'b11, 16'h0, 1'b0, 1'b0, 1'b0, a, e_, d, l, g);
            e = exp_q.pop_front();
            checks++;
            if (a !== 1'b1 || l != e.lat || d !== e.data || g !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_%0d: got ack=%b lat=%0d data=%h glitch=%b want 1 %0d %h 0", i, a, l, d, g, e.lat, e.data);
            end
        end
    endtask

    initial begin
        i_rst = 1'b1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = '0;
        wb_i_dat = 16'h0; wb_sel = 2'b00; wb_4_burst = 1'b0; wb_8_burst = 1'b0;
        @(negedge i_clk);
        preload(12'h100, 16'hBEEF);
        test_reset();
        test_single_read();
        test_byte_write();
        test_burst8();
        test_burst_addr_err();
        test_both_flags();
        test_abort(1'b0);
        test_abort(1'b1);
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
